// File: rtl/lift_group_dispatcher.sv
// Hall-call dispatcher for a bank of lift cars: latches hall buttons,
// assigns each call to one enabled car by cost, and keeps per-car queues.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   i_up_rqst/i_dn_rqst hall buttons, one bit per floor
//   i_car_en            car in service, one bit per car
//   i_car_flr_pos       binary floor index per car, car c at [c*FLR_W +: FLR_W]
//   i_car_dir           car direction, 1 = up
//   i_car_motion        car is moving
//   i_car_up_clr/dn_clr car served the call at its current floor
//   o_car_up_queue/dn   assigned calls, car c at [c*N_FLOORS +: N_FLOORS]
//   o_unassigned_up/dn  latched calls waiting for a car
//   o_busy              assignment FSM is evaluating or committing
module lift_group_dispatcher #(
  parameter int N_FLOORS = 8,
  parameter int N_CARS   = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_FLOORS-1:0]          i_up_rqst,
  input  logic [N_FLOORS-1:0]          i_dn_rqst,
  input  logic [N_CARS-1:0]            i_car_en,
  input  logic [N_CARS*$clog2(N_FLOORS)-1:0] i_car_flr_pos,
  input  logic [N_CARS-1:0]            i_car_dir,
  input  logic [N_CARS-1:0]            i_car_motion,
  input  logic [N_CARS-1:0]            i_car_up_clr,
  input  logic [N_CARS-1:0]            i_car_dn_clr,
  output logic [N_CARS*N_FLOORS-1:0]   o_car_up_queue,
  output logic [N_CARS*N_FLOORS-1:0]   o_car_dn_queue,
  output logic [N_FLOORS-1:0]          o_unassigned_up,
  output logic [N_FLOORS-1:0]          o_unassigned_dn,
  output logic                         o_busy
);

  localparam int FLR_W = $clog2(N_FLOORS);
  localparam int CST_W = FLR_W + 2;
  localparam int CAR_W = (N_CARS > 1) ? $clog2(N_CARS) : 1;
  localparam int QW    = N_CARS * N_FLOORS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EVAL,
    S_COMMIT
  } state_t;

  state_t             state_q, state_d;
  logic [CAR_W-1:0]   k_q, k_d;
  logic [FLR_W-1:0]   tgt_flr_q, tgt_flr_d;
  logic               tgt_up_q, tgt_up_d;
  logic [CAR_W-1:0]   best_q, best_d;
  logic [CST_W-1:0]   best_cost_q, best_cost_d;
  logic               best_vld_q, best_vld_d;
  logic [QW-1:0]      up_q, up_d;
  logic [QW-1:0]      dn_q, dn_d;
  logic [N_FLOORS-1:0] un_up_q, un_up_d;
  logic [N_FLOORS-1:0] un_dn_q, un_dn_d;

  // Cost of car k for the captured target call
  logic [FLR_W-1:0] pos_k;
  logic [FLR_W-1:0] dist_k;
  logic             away_k;
  logic             mis_k;
  logic [CST_W-1:0] cost_k;

  always_comb begin
    pos_k  = i_car_flr_pos[int'(k_q)*FLR_W +: FLR_W];
    dist_k = (pos_k > tgt_flr_q) ? (pos_k - tgt_flr_q)
                                 : (tgt_flr_q - pos_k);
    // Moving away means the target is behind the car's travel direction
    away_k = i_car_motion[k_q] &&
             ((i_car_dir[k_q] && (pos_k > tgt_flr_q)) ||
              (!i_car_dir[k_q] && (pos_k < tgt_flr_q)));
    mis_k  = i_car_motion[k_q] && (i_car_dir[k_q] != tgt_up_q);
    cost_k = {2'b00, dist_k};
    if (away_k) cost_k = cost_k + CST_W'(N_FLOORS);
    if (mis_k)  cost_k = cost_k + CST_W'(1);
  end

  // Target selection: lowest floor, up before down at the same floor
  logic               any_un;
  logic [FLR_W-1:0]   pick_flr;
  logic               pick_up;

  always_comb begin
    any_un   = (|un_up_q) || (|un_dn_q);
    pick_flr = '0;
    pick_up  = 1'b0;
    for (int f = N_FLOORS - 1; f >= 0; f--) begin
      if (un_dn_q[f]) begin
        pick_flr = FLR_W'(f);
        pick_up  = 1'b0;
      end
      if (un_up_q[f]) begin
        pick_flr = FLR_W'(f);
        pick_up  = 1'b1;
      end
    end
  end

  // Assignment FSM
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    tgt_flr_d   = tgt_flr_q;
    tgt_up_d    = tgt_up_q;
    best_d      = best_q;
    best_cost_d = best_cost_q;
    best_vld_d  = best_vld_q;
    unique case (state_q)
      S_IDLE: begin
        if (any_un && (|i_car_en)) begin
          tgt_flr_d  = pick_flr;
          tgt_up_d   = pick_up;
          k_d        = '0;
          best_vld_d = 1'b0;
          state_d    = S_EVAL;
        end
      end
      S_EVAL: begin
        // Strict compare keeps the lowest index on a tie
        if (i_car_en[k_q] &&
            (!best_vld_q || (cost_k < best_cost_q))) begin
          best_d      = k_q;
          best_cost_d = cost_k;
          best_vld_d  = 1'b1;
        end
        if (k_q == CAR_W'(N_CARS - 1)) begin
          state_d = S_COMMIT;
        end else begin
          k_d = k_q + CAR_W'(1);
        end
      end
      S_COMMIT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Queue and unassigned-vector bookkeeping
  logic [N_FLOORS-1:0] asg_up;
  logic [N_FLOORS-1:0] asg_dn;
  logic [N_FLOORS-1:0] drop_up;
  logic [N_FLOORS-1:0] drop_dn;
  logic [FLR_W-1:0]    pos_c;
  logic                do_commit;

  always_comb begin
    up_d    = up_q;
    dn_d    = dn_q;
    un_up_d = un_up_q;
    un_dn_d = un_dn_q;
    asg_up  = '0;
    asg_dn  = '0;
    drop_up = '0;
    drop_dn = '0;
    pos_c   = '0;

    for (int c = 0; c < N_CARS; c++) begin
      asg_up = asg_up | up_q[c*N_FLOORS +: N_FLOORS];
      asg_dn = asg_dn | dn_q[c*N_FLOORS +: N_FLOORS];
    end

    // Served calls leave the car's queue
    for (int c = 0; c < N_CARS; c++) begin
      pos_c = i_car_flr_pos[c*FLR_W +: FLR_W];
      if (i_car_up_clr[c]) up_d[c*N_FLOORS + int'(pos_c)] = 1'b0;
      if (i_car_dn_clr[c]) dn_d[c*N_FLOORS + int'(pos_c)] = 1'b0;
      // A stopped car serving the floor swallows a fresh button press
      if (i_car_en[c] && !i_car_motion[c]) begin
        if (i_car_up_clr[c]) drop_up[pos_c] = 1'b1;
        if (i_car_dn_clr[c]) drop_dn[pos_c] = 1'b1;
      end
    end

    // Latch only calls not already held anywhere
    un_up_d = un_up_d | (i_up_rqst & ~asg_up & ~drop_up);
    un_dn_d = un_dn_d | (i_dn_rqst & ~asg_dn & ~drop_dn);

    // A car dropped out of service aborts a commit to it
    do_commit = (state_q == S_COMMIT) && best_vld_q && i_car_en[best_q];
    if (do_commit) begin
      if (tgt_up_q) begin
        up_d[int'(best_q)*N_FLOORS + int'(tgt_flr_q)] = 1'b1;
        un_up_d[tgt_flr_q] = 1'b0;
      end else begin
        dn_d[int'(best_q)*N_FLOORS + int'(tgt_flr_q)] = 1'b1;
        un_dn_d[tgt_flr_q] = 1'b0;
      end
    end

    // Disabled cars hand their calls back to the pool
    for (int c = 0; c < N_CARS; c++) begin
      if (!i_car_en[c]) begin
        un_up_d = un_up_d | up_d[c*N_FLOORS +: N_FLOORS];
        un_dn_d = un_dn_d | dn_d[c*N_FLOORS +: N_FLOORS];
        up_d[c*N_FLOORS +: N_FLOORS] = '0;
        dn_d[c*N_FLOORS +: N_FLOORS] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      tgt_flr_q   <= '0;
      tgt_up_q    <= 1'b0;
      best_q      <= '0;
      best_cost_q <= '0;
      best_vld_q  <= 1'b0;
      up_q        <= '0;
      dn_q        <= '0;
      un_up_q     <= '0;
      un_dn_q     <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      tgt_flr_q   <= tgt_flr_d;
      tgt_up_q    <= tgt_up_d;
      best_q      <= best_d;
      best_cost_q <= best_cost_d;
      best_vld_q  <= best_vld_d;
      up_q        <= up_d;
      dn_q        <= dn_d;
      un_up_q     <= un_up_d;
      un_dn_q     <= un_dn_d;
    end
  end

  assign o_car_up_queue  = up_q;
  assign o_car_dn_queue  = dn_q;
  assign o_unassigned_up = un_up_q;
  assign o_unassigned_dn = un_dn_q;
  assign o_busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_lift_group_dispatcher.sv
// Bench for lift_group_dispatcher: directed hall calls with a scoreboard
// of expected (car, direction, floor, cycle) assignments.
module tb_lift_group_dispatcher;

  localparam int NF = 8;
  localparam int NC = 4;
  localparam int FW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [NF-1:0] up_rqst, dn_rqst;
  logic [NC-1:0] car_en, car_dir, car_motion, up_clr, dn_clr;
  logic [NC*FW-1:0] car_pos;
  logic [FW-1:0] pos [NC];
  logic [NC*NF-1:0] up_qo, dn_qo;
  logic [NF-1:0] un_up, un_dn;
  logic          busy;

  always #5 clk = ~clk;

  always_comb begin
    car_pos = '0;
    for (int c = 0; c < NC; c++) car_pos[c*FW +: FW] = pos[c];
  end

  lift_group_dispatcher #(.N_FLOORS(NF), .N_CARS(NC)) dut (
    .clk(clk), .reset(reset),
    .i_up_rqst(up_rqst), .i_dn_rqst(dn_rqst),
    .i_car_en(car_en), .i_car_flr_pos(car_pos),
    .i_car_dir(car_dir), .i_car_motion(car_motion),
    .i_car_up_clr(up_clr), .i_car_dn_clr(dn_clr),
    .o_car_up_queue(up_qo), .o_car_dn_queue(dn_qo),
    .o_unassigned_up(un_up), .o_unassigned_dn(un_dn),
    .o_busy(busy)
  );

  typedef struct {
    int car;
    bit up;
    int flr;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  logic [NC*NF-1:0] prev_up = '0, prev_dn = '0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic got(input int c, input bit up, input int f);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL unexpected_assign: got car%0d up=%0d flr%0d expected none",
               c, up, f);
    end else begin
      e = sb.pop_front();
      if (e.car != c || e.up != up || e.flr != f ||
          (e.cyc >= 0 && e.cyc != cyc)) begin
        errors++;
        $display("FAIL assign: got car%0d up=%0d flr%0d cyc%0d expected car%0d up=%0d flr%0d cyc%0d",
                 c, up, f, cyc, e.car, e.up, e.flr, e.cyc);
      end
    end
  endtask

  // Monitor: every newly set queue bit is one assignment
  always @(posedge clk) begin
    logic [NC*NF-1:0] nu, nd;
    cyc++;
    #1;
    nu = up_qo & ~prev_up;
    nd = dn_qo & ~prev_dn;
    for (int c = 0; c < NC; c++)
      for (int f = 0; f < NF; f++) begin
        if (nu[c*NF+f]) got(c, 1'b1, f);
        if (nd[c*NF+f]) got(c, 1'b0, f);
      end
    prev_up = up_qo;
    prev_dn = dn_qo;
  end

  function automatic logic [NF-1:0] upq(input int c);
    return up_qo[c*NF +: NF];
  endfunction

  function automatic logic [NF-1:0] dnq(input int c);
    return dn_qo[c*NF +: NF];
  endfunction

  task automatic cars(input logic [NC-1:0] en, input logic [NC-1:0] mo,
                      input logic [NC-1:0] dr, input int p0, input int p1,
                      input int p2, input int p3);
    car_en = en; car_motion = mo; car_dir = dr;
    pos[0] = FW'(p0); pos[1] = FW'(p1);
    pos[2] = FW'(p2); pos[3] = FW'(p3);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    up_rqst = '0; dn_rqst = '0; up_clr = '0; dn_clr = '0;
    cars('0, '0, '0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // One-cycle button pulse; car<0 means no assignment expected
  task automatic req(input bit up, input int f, input int car,
                     input bit timed);
    exp_t e;
    @(negedge clk);
    if (up) up_rqst[f] = 1'b1;
    else    dn_rqst[f] = 1'b1;
    if (car >= 0) begin
      e.car = car; e.up = up; e.flr = f;
      e.cyc = timed ? cyc + 7 : -1;
      sb.push_back(e);
    end
    @(negedge clk);
    up_rqst = '0;
    dn_rqst = '0;
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while (sb.size() != 0 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    reset = 1'b1;
    up_rqst = '0; dn_rqst = '0; up_clr = '0; dn_clr = '0;
    cars('0, '0, '0, 0, 0, 0, 0);

    // 1: nearest stopped car, then clear behaviour
    do_reset();
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_un", {16'h0, un_up, un_dn}, 0);
    chk("rst_upq", up_qo, 0);
    chk("rst_dnq", dn_qo, 0);
    cars(4'hf, '0, '0, 0, 2, 5, 7);
    req(1'b1, 4, 2, 1'b1);
    drain(20);
    chk("t1_q2", 32'(upq(2)), 32'h10);
    chk("t1_un", 32'(un_up), 0);
    @(negedge clk);
    up_clr[2] = 1'b1;
    @(negedge clk);
    up_clr = '0;
    chk("t1_clr_other_flr", 32'(upq(2)), 32'h10);
    pos[2] = 3'd4;
    up_clr[2] = 1'b1;
    @(negedge clk);
    up_clr = '0;
    chk("t1_clr", 32'(upq(2)), 0);

    // 2: clear swallows a press, then tie to lowest index
    do_reset();
    cars(4'hf, '0, '0, 3, 3, 0, 7);
    @(negedge clk);
    dn_rqst[3] = 1'b1;
    dn_clr[1] = 1'b1;
    @(negedge clk);
    dn_rqst = '0;
    dn_clr = '0;
    chk("t2_drop_un", 32'(un_dn), 0);
    chk("t2_drop_busy", 32'(busy), 0);
    req(1'b0, 3, 0, 1'b1);
    drain(20);
    chk("t2_q0", 32'(dnq(0)), 32'h08);
    chk("t2_q1", 32'(dnq(1)), 0);

    // 3: moving-away penalty
    do_reset();
    cars(4'b0011, 4'b0010, 4'b0010, 6, 2, 0, 0);
    req(1'b1, 1, 0, 1'b1);
    drain(20);
    chk("t3_q0", 32'(upq(0)), 32'h02);

    // 7: direction-mismatch penalty and tie
    do_reset();
    cars(4'b0011, 4'b0001, 4'b0000, 3, 3, 0, 0);
    req(1'b1, 1, 1, 1'b1);
    drain(20);
    req(1'b0, 1, 0, 1'b1);
    drain(20);
    chk("t7_up1", 32'(upq(1)), 32'h02);
    chk("t7_dn0", 32'(dnq(0)), 32'h02);

    // 4: disable returns calls, reassigned floor 1 first
    do_reset();
    cars(4'b1000, '0, '0, 0, 0, 0, 0);
    req(1'b1, 1, 3, 1'b1);
    drain(20);
    req(1'b1, 6, 3, 1'b1);
    drain(20);
    chk("t4_q3", 32'(upq(3)), 32'h42);
    @(negedge clk);
    cars(4'b0111, '0, '0, 7, 0, 4, 0);
    e.car = 1; e.up = 1'b1; e.flr = 1; e.cyc = -1;
    sb.push_back(e);
    e.car = 0; e.up = 1'b1; e.flr = 6; e.cyc = -1;
    sb.push_back(e);
    @(negedge clk);
    chk("t4_q3_gone", 32'(upq(3)), 0);
    chk("t4_un", 32'(un_up), 32'h42);
    drain(40);
    chk("t4_un_end", 32'(un_up), 0);

    // 5: no car in service
    do_reset();
    req(1'b1, 2, -1, 1'b0);
    repeat (3) @(negedge clk);
    chk("t5_un", 32'(un_up), 32'h04);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_q", up_qo, 0);
    car_en[0] = 1'b1;
    e.car = 0; e.up = 1'b1; e.flr = 2; e.cyc = cyc + 6;
    sb.push_back(e);
    drain(20);
    chk("t5_un_end", 32'(un_up), 0);

    // 6: reset mid-evaluation, then retry
    do_reset();
    cars(4'hf, '0, '0, 0, 2, 5, 7);
    req(1'b1, 4, -1, 1'b0);
    @(negedge clk);
    chk("t6_busy", 32'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t6_busy_rst", 32'(busy), 0);
    chk("t6_un_rst", {16'h0, un_up, un_dn}, 0);
    chk("t6_q_rst", up_qo, 0);
    req(1'b1, 4, 2, 1'b1);
    drain(20);
    chk("t6_q2", 32'(upq(2)), 32'h10);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
